// File: rtl/ldpc_iter_ctrl.sv
// ============================================================================
// Module   : ldpc_iter_ctrl
// Brief    : Iteration sequencer for the 6x3 flooding LDPC decoder datapath.
//            Loads LLRs, times the settle window, samples the syndrome and
//            pulses the VN message latch. Results leave on a valid/ready port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ldpc_iter_ctrl #(
    parameter int ITER_W     = 20,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ITER_W-1:0] max_num_iter,
    input  logic              abort,
    input  logic              syndrome_ok,
    output logic              load_llr,
    output logic              latch_vn,
    output logic              use_belief,
    output logic              busy,
    output logic              done_valid,
    input  logic              done_ready,
    output logic [1:0]        status,
    output logic [ITER_W-1:0] iterations_num
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_LATCH  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYC - 1);
    localparam logic [1:0] c_ST_CONV     = 2'b01;
    localparam logic [1:0] c_ST_LIMIT    = 2'b10;
    localparam logic [1:0] c_ST_ABORT    = 2'b11;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_settle_cnt;
    logic [ITER_W-1:0] r_limit;
    logic [ITER_W-1:0] r_iter;
    logic [1:0]        r_status;
    logic              r_use_belief;
    logic              w_abort_hit;
    logic              w_at_limit;

    // Abort only matters while the datapath is actively iterating.
    assign w_abort_hit = abort && (r_state == S_LOAD || r_state == S_SETTLE ||
                                   r_state == S_CHECK || r_state == S_LATCH);
    assign w_at_limit  = (r_iter == r_limit);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_LOAD;
            S_LOAD:   w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_settle_cnt == 4'd0) w_state_nxt = S_CHECK;
            S_CHECK:  w_state_nxt = (syndrome_ok || w_at_limit) ? S_DONE : S_LATCH;
            S_LATCH:  w_state_nxt = S_SETTLE;
            S_DONE:   if (done_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (w_abort_hit) w_state_nxt = S_DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= 4'd0;
            r_limit      <= '0;
            r_iter       <= '0;
            r_status     <= 2'b00;
            r_use_belief <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_limit      <= max_num_iter;
                        r_iter       <= '0;
                        r_use_belief <= 1'b0;
                        r_status     <= 2'b00;
                    end
                end
                S_LOAD: r_settle_cnt <= c_SETTLE_LOAD;
                S_SETTLE: begin
                    if (r_settle_cnt != 4'd0) r_settle_cnt <= r_settle_cnt - 4'd1;
                end
                S_CHECK: begin
                    if (syndrome_ok)     r_status <= c_ST_CONV;
                    else if (w_at_limit) r_status <= c_ST_LIMIT;
                end
                S_LATCH: begin
                    r_iter       <= r_iter + 1'b1;
                    r_use_belief <= 1'b1;
                    r_settle_cnt <= c_SETTLE_LOAD;
                end
                default: ;
            endcase
            // Placed last so an abort overrides the CHECK verdict.
            if (w_abort_hit) r_status <= c_ST_ABORT;
        end
    end

    assign load_llr       = (r_state == S_LOAD);
    assign latch_vn       = (r_state == S_LATCH);
    assign busy           = (r_state != S_IDLE);
    assign done_valid     = (r_state == S_DONE);
    assign use_belief     = r_use_belief;
    assign status         = r_status;
    assign iterations_num = r_iter;

endmodule

`default_nettype wire

// File: tb/tb_ldpc_iter_ctrl.sv
// ============================================================================
// Module   : tb_ldpc_iter_ctrl
// Brief    : Scoreboard bench for ldpc_iter_ctrl (directed decodes).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ldpc_iter_ctrl;

    localparam int ITER_W     = 20;
    localparam int SETTLE_CYC = 2;
    localparam int ITER_CYC   = SETTLE_CYC + 2;
    localparam int TMO        = 300;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ITER_W-1:0] max_num_iter = '0;
    logic              abort = 1'b0;
    logic              syndrome_ok = 1'b0;
    logic              done_ready = 1'b0;
    logic              load_llr, latch_vn, use_belief, busy, done_valid;
    logic [1:0]        status;
    logic [ITER_W-1:0] iterations_num;

    ldpc_iter_ctrl #(.ITER_W(ITER_W), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk(clk), .rst(rst), .start(start), .max_num_iter(max_num_iter),
        .abort(abort), .syndrome_ok(syndrome_ok), .load_llr(load_llr),
        .latch_vn(latch_vn), .use_belief(use_belief), .busy(busy),
        .done_valid(done_valid), .done_ready(done_ready), .status(status),
        .iterations_num(iterations_num)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]        st;
        logic [ITER_W-1:0] it;
        int                lat;
        int                nl;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   load_cyc = 0;
    int   n_latch  = 0;
    logic prev_dv  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [1:0] st, input int it, input int lat, input int nl);
        exp_t e;
        e.st = st; e.it = ITER_W'(it); e.lat = lat; e.nl = nl;
        q.push_back(e);
    endtask

    task automatic wait_latch();
        int n = 0;
        do begin tick(); n++; end while (!latch_vn && n < TMO);
        if (!latch_vn) chk("wait_latch_timeout", 1, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin tick(); n++; end while (!done_valid && n < TMO);
        if (!done_valid) chk("wait_done_timeout", 1, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin tick(); n++; end while (busy && n < TMO);
        if (busy) chk("wait_idle_timeout", 1, 0);
    endtask

    // Launch from a negedge; returns at the negedge of the LOAD cycle.
    task automatic start_decode(input int max_it, input string name);
        max_num_iter = ITER_W'(max_it);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({name, "_load_llr"}, load_llr, 1);
    endtask

    // Scoreboard monitor: on each done_valid rise compare against the queue.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                n_latch = 0;
                prev_dv = 1'b0;
            end else begin
                if (load_llr) begin load_cyc = cyc; n_latch = 0; end
                if (latch_vn) n_latch++;
                if (done_valid && !prev_dv) begin
                    if (q.size() == 0) begin
                        chk("sb_unexpected_done", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("sb_status", status, e.st);
                        chk("sb_iterations", iterations_num, e.it);
                        chk("sb_latency", cyc - load_cyc, e.lat);
                        chk("sb_latch_count", n_latch, e.nl);
                    end
                end
                prev_dv = done_valid;
            end
        end
    end

    initial begin : stim
        int held;
        repeat (3) tick();
        chk("reset_outputs",
            {load_llr, latch_vn, use_belief, busy, done_valid, status, iterations_num}, 0);
        rst = 1'b0;
        done_ready = 1'b1;
        tick();

        // Immediate convergence
        syndrome_ok = 1'b1;
        push(2'b01, 0, ITER_CYC, 0);
        start_decode(7, "t1");
        wait_idle();
        chk("t1_idle_status", status, 2'b01);
        chk("t1_idle_iter", iterations_num, 0);

        // Limit reached after 3 latches
        syndrome_ok = 1'b0;
        push(2'b10, 3, ITER_CYC * 4, 3);
        start_decode(3, "t2");
        chk("t2_belief_initial", use_belief, 0);
        wait_latch();
        tick();
        chk("t2_belief_after_latch", use_belief, 1);
        wait_idle();

        // Converges after the second latch; consumer stalls
        done_ready = 1'b0;
        push(2'b01, 2, ITER_CYC * 3, 2);
        start_decode(5, "t3");
        wait_latch();
        wait_latch();
        syndrome_ok = 1'b1;
        wait_done();
        held = 0;
        repeat (3) begin tick(); if (done_valid) held++; end
        chk("t3_done_held", held, 3);
        chk("t3_status_held", status, 2'b01);
        done_ready = 1'b1;
        tick();
        chk("t3_released", {done_valid, busy}, 2'b00);
        syndrome_ok = 1'b0;
        tick();

        // Zero iteration limit
        push(2'b10, 0, ITER_CYC, 0);
        start_decode(0, "t4");
        wait_idle();

        // Abort in first SETTLE after latch 1, then start while in DONE
        done_ready = 1'b0;
        push(2'b11, 1, ITER_CYC * 2 - 2, 1);
        start_decode(5, "t5");
        wait_latch();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_done", done_valid, 1);
        start = 1'b1;
        tick();
        chk("t5_start_in_done", {load_llr, done_valid}, 2'b01);
        done_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_start_with_ready", {load_llr, busy}, 2'b00);
        tick();
        chk("t5_no_load_after", load_llr, 0);
        chk("t5_idle_status", {status, iterations_num}, {2'b11, 20'd1});

        // Reset mid-SETTLE at iteration 2, then a fresh decode
        start_decode(5, "t6");
        wait_latch();
        wait_latch();
        tick();
        rst = 1'b1;
        tick();
        chk("t6_reset_outputs",
            {load_llr, latch_vn, use_belief, busy, done_valid, status, iterations_num}, 0);
        rst = 1'b0;
        tick();
        syndrome_ok = 1'b1;
        push(2'b01, 0, ITER_CYC, 0);
        start_decode(9, "t6b");
        wait_idle();

        repeat (4) tick();
        chk("sb_queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
